// File: rtl/tiny_yolo_pkg.sv
// Shared widths, typedefs and per-lane requantisation arithmetic for the tiny-yolo datapath.
package tiny_yolo_pkg;
    localparam int unsigned LANES     = 8;
    localparam int unsigned ACC_W     = 32;
    localparam int unsigned OUT_W     = 8;
    localparam int unsigned SCALE_W   = 16;
    localparam int unsigned SHIFT_W   = 5;
    localparam int unsigned LEAKY_MUL = 13;
    localparam int unsigned LEAKY_SHR = 7;
    // Product width plus headroom for rounding and the leaky multiply.
    localparam int unsigned P_W = ACC_W + SCALE_W + 1;
    localparam int unsigned R_W = P_W + 5;

    typedef logic signed [ACC_W-1:0] acc_vec_t [LANES];
    typedef logic [LANES*OUT_W-1:0] pix_t;

    // Round-half-up right shift, then optional leaky slope (flooring) on negatives.
    function automatic logic signed [R_W-1:0] round_leaky(
        input logic signed [P_W-1:0] p,
        input logic [SHIFT_W-1:0]    shift,
        input logic                  leaky
    );
        logic signed [R_W-1:0] x;
        x = {{(R_W-P_W){p[P_W-1]}}, p};
        if (shift != '0)
            x = x + (R_W'(1) <<< (shift - SHIFT_W'(1)));
        x = x >>> shift;
        if (leaky && (x < 0))
            x = (x * $signed(R_W'(LEAKY_MUL))) >>> LEAKY_SHR;
        return x;
    endfunction

    function automatic logic [OUT_W-1:0] sat_lane(input logic signed [R_W-1:0] r);
        logic signed [R_W-1:0] hi;
        logic signed [R_W-1:0] lo;
        hi = R_W'((1 << (OUT_W-1)) - 1);
        lo = -hi - R_W'(1);
        if (r > hi)
            return {1'b0, {(OUT_W-1){1'b1}}};
        if (r < lo)
            return {1'b1, {(OUT_W-1){1'b0}}};
        return r[OUT_W-1:0];
    endfunction
endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; a push when full is taken only alongside a pop.
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++)
                mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/conv_out_requant.sv
// Requantises conv_1x1 accumulator beats to packed int8 pixels behind a ready/valid FIFO.
module conv_out_requant #(
    parameter int unsigned LANES      = 8,
    parameter int unsigned ACC_W      = 32,
    parameter int unsigned OUT_W      = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      data_valid,
    input  logic signed [ACC_W-1:0]   outs [LANES],
    input  logic [15:0]               cfg_scale,
    input  logic [4:0]                cfg_shift,
    input  logic                      cfg_leaky,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [LANES*OUT_W-1:0]    m_data,
    output logic                      overflow,
    output logic                      busy
);
    import tiny_yolo_pkg::*;

    logic                     v1;
    logic                     v2;
    logic                     v3;
    logic [SHIFT_W-1:0]       shift_q;
    logic                     leaky_q;
    logic signed [P_W-1:0]    p_q [LANES];
    logic signed [R_W-1:0]    r_q [LANES];
    logic [LANES*OUT_W-1:0]   pix_d;
    logic [LANES*OUT_W-1:0]   pix_q;
    logic                     full;
    logic                     empty;

    // Stage 1: scale multiply; shift/leaky travel with the beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1      <= 1'b0;
            shift_q <= '0;
            leaky_q <= 1'b0;
            for (int i = 0; i < int'(LANES); i++)
                p_q[i] <= '0;
        end else begin
            v1 <= data_valid;
            if (data_valid) begin
                shift_q <= cfg_shift;
                leaky_q <= cfg_leaky;
                for (int i = 0; i < int'(LANES); i++)
                    p_q[i] <= P_W'(outs[i]) * P_W'($signed({1'b0, cfg_scale}));
            end
        end
    end

    // Stage 2: round, shift, leaky.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2 <= 1'b0;
            for (int i = 0; i < int'(LANES); i++)
                r_q[i] <= '0;
        end else begin
            v2 <= v1;
            if (v1) begin
                for (int i = 0; i < int'(LANES); i++)
                    r_q[i] <= round_leaky(p_q[i], shift_q, leaky_q);
            end
        end
    end

    always_comb begin
        pix_d = '0;
        for (int i = 0; i < int'(LANES); i++)
            pix_d[i*OUT_W +: OUT_W] = sat_lane(r_q[i]);
    end

    // Stage 3: saturated, packed word waiting to enter the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3       <= 1'b0;
            pix_q    <= '0;
            overflow <= 1'b0;
        end else begin
            v3 <= v2;
            if (v2)
                pix_q <= pix_d;
            if (v3 && full && !m_ready)
                overflow <= 1'b1;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (LANES*OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (v3),
        .din   (pix_q),
        .pop   (m_ready),
        .full  (full),
        .empty (empty),
        .dout  (m_data)
    );

    assign m_valid = !empty;
    assign busy    = v1 || v2 || v3 || !empty;
endmodule

// File: doc/conv_out_requant.md
# conv_out_requant

Output-side companion to `conv_1x1`. It consumes the 8-lane, 32-bit accumulator bundle that `conv_1x1` emits on `data_valid`. Each lane is scaled, rounded and shifted, optionally passed through leaky-ReLU, then saturated to int8. The eight results are packed into one 64-bit pixel word, buffered in a small FIFO, and presented on a ready/valid stream toward the feature-map writer.

## Interface
Parameters:
- `LANES`, 8: output channels per beat; must match `conv_1x1`.
- `ACC_W`, 32: accumulator width per lane.
- `OUT_W`, 8: quantised output width per lane.
- `FIFO_DEPTH`, 4: output buffer entries; power of two.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `data_valid`  in  1  accumulator bundle valid, one-cycle pulse per beat; no backpressure toward `conv_1x1`.
- `outs[0:LANES-1]`  in  ACC_W each  signed accumulators, bias already included.
- `cfg_scale`  in  16  unsigned multiplier.
- `cfg_shift`  in  5  right-shift amount, 0–31.
- `cfg_leaky`  in  1  enables leaky-ReLU on negative values.
- `m_valid`  out  1  output word available.
- `m_ready`  in  1  downstream accepts the word.
- `m_data`  out  LANES*OUT_W  packed int8 lanes; lane i sits at bits `[8i+7:8i]`.
- `overflow`  out  1  sticky; set when a beat is dropped because the FIFO is full.
- `busy`  out  1  high if any pipeline stage is valid or the FIFO is non-empty.

## Operation
- Stage 1, on the beat where `data_valid` is high:
  - per lane, `p = outs[i] * $signed({1'b0,cfg_scale})`; `p` is 49 bits signed.
  - `cfg_shift` and `cfg_leaky` are captured alongside the data. Config changes therefore affect only later beats, never a beat already in flight.
- Stage 2, per lane:
  - `r = (p + (shift==0 ? 0 : 1<<(shift-1))) >>> shift`, arithmetic shift (round half up).
  - If leaky is enabled and `r < 0`, then `r = (r*13) >>> 7`; the arithmetic shift floors.
  - Widths are kept sufficient that no intermediate wraps.
- Stage 3, per lane: saturate `r` to [-128, 127]; pack lanes.
- FIFO:
  - Stage-3 valid pushes the packed word.
  - `m_valid && m_ready` pops.
  - The FIFO is first-word fall-through, so `m_data` shows the head entry whenever `m_valid` is high.
- Full FIFO:
  - If stage 3 is valid, the FIFO is full and there is no pop in the same cycle, the new word is dropped and `overflow` is set.
  - `overflow` clears only on `rst`.
- Full FIFO with simultaneous push and pop: both proceed; occupancy is unchanged and nothing is dropped.
- Empty FIFO with push: the word becomes visible the next cycle. There is no bypass.
- `m_data` holds its value while `m_valid && !m_ready`, as the stream protocol requires.

## Timing
- Reset values: `m_valid=0`, `m_data=0`, `overflow=0`, `busy=0`; all stage valid bits 0; FIFO pointers 0.
- Latency with an empty FIFO and `m_ready=1`: `data_valid` is sampled at edge E0, so `m_valid` goes high after edge E3, i.e. 3 cycles.
- Throughput is one beat per cycle, fully pipelined with no stalls. Backpressure is absorbed only by the FIFO.
- Asserting `rst` mid-operation immediately discards in-flight beats and FIFO contents; nothing is emitted after reset releases until new `data_valid` beats arrive.
- `busy` is combinational from the stage valid bits and the FIFO count.

## Structure
- Shared package `tiny_yolo_pkg` holds:
  - `LANES`, `ACC_W`, `OUT_W`;
  - the constants `LEAKY_MUL=13` and `LEAKY_SHR=7`;
  - typedef `acc_vec_t` (`logic signed [ACC_W-1:0]` array of `LANES`);
  - typedef `pix_t` (`logic [LANES*OUT_W-1:0]`).
- One sub-module, `sync_fifo_fwft` (parameters WIDTH and DEPTH; ports `push`, `pop`, `full`, `empty`, `dout`). It is reusable by the input-side feeder.
- The per-lane arithmetic is a function in the package, not a module.

## Test plan
- Pass-through: `outs[i] = 17+i`, scale 1, shift 0, leaky 0 → `m_data` lane 0 = 0x11 and lane 7 = 0x18; `m_valid` rises exactly 3 cycles after `data_valid`.
- Saturation: `outs[0] = 1000` and `outs[1] = -1000`, scale 1, shift 0 → lane 0 = 0x7F, lane 1 = 0x80.
- Rounding: scale 1, shift 1, `outs[0] = 3` and `outs[1] = -3` → lane 0 = 2, lane 1 = -1 (0xFF). Also scale 3, shift 2, `outs[0] = 5` → (15+2)>>2 = 4.
- Leaky: `outs[0] = -100` and `outs[1] = 50`, scale 1, shift 0, leaky 1 → lane 0 = -11 (0xF5), lane 1 = 50 (0x32).
- Backpressure and overflow:
  - Hold `m_ready=0` and issue 5 back-to-back beats with lane 0 = 1..5 → 4 entries are retained and `overflow` goes high after the 5th beat reaches stage 3.
  - Then set `m_ready=1` → words with lane 0 = 1, 2, 3, 4 appear in order, then `m_valid=0` and `busy=0`; `overflow` stays 1.
- Reset mid-stream: issue 2 beats and assert `rst` one cycle later → all outputs read 0 and no word appears after release; a new beat then produces its correct result with 3-cycle latency.
